masked_subbytes_collector: RTL

//  Downstream of the 2-share masked S-box step-2 stage. Tracks bytes issued into the S-box

---
 rtl/aes_mask_pkg.sv | 23 ++
 rtl/valid_delay_line.sv | 30 +++
 rtl/masked_subbytes_collector.sv | 114 +++++++++++
 3 files changed

// File: rtl/aes_mask_pkg.sv
// Shared definitions for the masked AES datapath stages: byte/share
// geometry, the two-share state type and the ShiftRows byte mapping.
package aes_mask_pkg;

   localparam int NUM_BYTES = 16;
   localparam int BYTE_W    = 8;
   localparam int SHARES    = 2;

   typedef logic [NUM_BYTES*BYTE_W-1:0] state_t;
   typedef logic [4:0]                  cnt_t;
   typedef logic [3:0]                  idx_t;

   // i = 4c + r (column-major); byte lands at column (c - r) mod 4.
   // The 2-bit subtraction wraps, which is exactly the mod 4.
   function automatic idx_t shiftrows_pos(input idx_t i);
      logic [1:0] r;
      logic [1:0] c;
      r = i[1:0];
      c = i[3:2];
      return {c - r, r};
   endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that tags S-box results with their issue
// pulse.  Ports: clk, rst (sync, active-high), in (tag in), out (tag out).
module valid_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= in;
         end
      end else begin : g_many
         always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= {sr[DEPTH-2:0], in};
         end
      end
   endgenerate

   assign out = sr[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_collector.sv
// Collects 16 masked S-box byte pairs into a two-share AES state.
// Ports: issue_valid/issue_ready (bytes entering the S-box), sbox_out0/1
// (share outputs), state0/1 + state_valid/state_ready (assembled state).
module masked_subbytes_collector
   import aes_mask_pkg::*;
#(
   parameter int SBOX_LATENCY    = 2,
   parameter bit APPLY_SHIFTROWS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [BYTE_W-1:0] sbox_out0,
   input  logic [BYTE_W-1:0] sbox_out1,
   output state_t            state0,
   output state_t            state1,
   output logic              state_valid,
   input  logic              state_ready
);

   localparam cnt_t FULL = cnt_t'(NUM_BYTES);
   localparam cnt_t LAST = cnt_t'(NUM_BYTES - 1);

   logic                 issue_fire;
   logic                 cap_en;
   logic                 cap_ok;
   logic                 handshake;
   cnt_t                 issued_cnt;
   cnt_t                 recv_cnt;
   idx_t                 wr_idx;
   idx_t                 wr_pos;
   logic [NUM_BYTES-1:0] wr_sel;
   logic [BYTE_W-1:0]    buf0 [NUM_BYTES];
   logic [BYTE_W-1:0]    buf1 [NUM_BYTES];

   assign issue_ready = (issued_cnt != FULL);
   assign issue_fire  = issue_valid & issue_ready;
   assign handshake   = state_valid & state_ready;
   // A tag arriving with all 16 bytes already held is dropped.
   assign cap_ok      = cap_en & (recv_cnt != FULL);

   // Tags only for accepted issues; reset wipes in-flight tags.
   valid_delay_line #(
      .DEPTH (SBOX_LATENCY)
   ) u_tags (
      .clk (clk),
      .rst (rst),
      .in  (issue_fire),
      .out (cap_en)
   );

   // Write position depends only on the arrival count, never on data.
   assign wr_idx = recv_cnt[3:0];
   assign wr_pos = APPLY_SHIFTROWS ? shiftrows_pos(wr_idx) : wr_idx;

   always_comb begin
      wr_sel = '0;
      if (cap_ok) wr_sel[wr_pos] = 1'b1;
   end

   // Share 0 buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_BYTES; k++) buf0[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_BYTES; k++)
            if (wr_sel[k]) buf0[k] <= sbox_out0;
      end
   end

   // Share 1 buffer, kept physically separate from share 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_BYTES; k++) buf1[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_BYTES; k++)
            if (wr_sel[k]) buf1[k] <= sbox_out1;
      end
   end

   // Block control: counters and the output valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt  <= '0;
         recv_cnt    <= '0;
         state_valid <= 1'b0;
      end else if (handshake) begin
         issued_cnt  <= '0;
         recv_cnt    <= '0;
         state_valid <= 1'b0;
      end else begin
         if (issue_fire) issued_cnt <= issued_cnt + 1'b1;
         if (cap_ok) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST) state_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      state0 = '0;
      state1 = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         state0[k*BYTE_W +: BYTE_W] = buf0[k];
         state1[k*BYTE_W +: BYTE_W] = buf1[k];
      end
   end

   capture_overrun : assert property (
      @(posedge clk) disable iff (rst) !(cap_en && (recv_cnt == FULL))
   );

endmodule
